// File: rtl/ps2_frame_receiver.sv
// ---------------------------------------------------------------------------
// ps2_frame_receiver
//   Conditions the raw PS/2 clock/data lines in the clk domain. It then
//   assembles 11-bit frames (start, d0..d7 LSB-first, odd parity, stop) and
//   validates them. It also tracks make/break codes so that keyFrame holds
//   the frame of the currently pressed key.
//
// Ports
//   clk        in   system clock, all state on the rising edge
//   resetN     in   asynchronous active-low reset
//   ps2Clk     in   raw PS/2 clock, asynchronous to clk
//   ps2Data    in   raw PS/2 data, asynchronous to clk
//   keyFrame   out  [10:0] frame of the held key, 0 when no key is held
//   frameOut   out  [10:0] last valid frame received
//   frameValid out  one-cycle pulse when frameOut updates
//   frameErr   out  one-cycle pulse on start/stop/parity error or timeout
//
// FSM states
//   ST_IDLE  | waiting for a start bit (fall strobe with data 0)
//   ST_SHIFT | collecting bits 2..11, gap timer running
//   ST_CHECK | one cycle: validate the frame and update key tracking
// ---------------------------------------------------------------------------
module ps2_frame_receiver #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        ps2Clk,
    input  logic        ps2Data,
    output logic [10:0] keyFrame,
    output logic [10:0] frameOut,
    output logic        frameValid,
    output logic        frameErr
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int GW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [GW-1:0] GAP_MAX   = GW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    // input conditioning
    logic          r_clk_s1, r_clk_s2;
    logic          r_dat_s1, r_dat_s2;
    logic          r_filt, r_filt_d;
    logic [FW-1:0] r_fcnt;
    logic          w_fall;

    // frame state
    state_t        r_state, w_state_nxt;
    logic [10:0]   r_shreg, w_shreg_nxt;
    logic [3:0]    r_bitcnt, w_bitcnt_nxt;
    logic [GW-1:0] r_gap, w_gap_nxt;
    logic [10:0]   r_frame_out, w_frame_out_nxt;
    logic [10:0]   r_key, w_key_nxt;
    logic          r_break, w_break_nxt;
    logic          r_valid, w_valid_nxt;
    logic          r_err, w_err_nxt;

    logic [10:0]   w_shifted;
    logic [7:0]    w_byte;
    logic          w_frame_ok;

    assign w_fall = r_filt_d & ~r_filt;

    // The filter counts consecutive synchronized samples that disagree with
    // the filtered level. Any agreeing sample restarts the count.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
            r_filt   <= 1'b1;
            r_filt_d <= 1'b1;
            r_fcnt   <= '0;
        end else begin
            r_clk_s1 <= ps2Clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2Data;
            r_dat_s2 <= r_dat_s1;
            r_filt_d <= r_filt;
            if (r_clk_s2 == r_filt) begin
                r_fcnt <= '0;
            end else if (r_fcnt == FILT_LAST) begin
                r_fcnt <= '0;
                r_filt <= r_clk_s2;
            end else begin
                r_fcnt <= r_fcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state     <= ST_IDLE;
            r_shreg     <= '0;
            r_bitcnt    <= '0;
            r_gap       <= '0;
            r_frame_out <= '0;
            r_key       <= '0;
            r_break     <= 1'b0;
            r_valid     <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shreg     <= w_shreg_nxt;
            r_bitcnt    <= w_bitcnt_nxt;
            r_gap       <= w_gap_nxt;
            r_frame_out <= w_frame_out_nxt;
            r_key       <= w_key_nxt;
            r_break     <= w_break_nxt;
            r_valid     <= w_valid_nxt;
            r_err       <= w_err_nxt;
        end
    end

    assign w_shifted = {r_shreg[9:0], r_dat_s2};

    // shreg[9] holds d0, so the byte is shreg[9:2] bit-reversed
    always_comb begin
        w_byte = '0;
        for (int i = 0; i < 8; i++) begin
            w_byte[i] = r_shreg[9-i];
        end
    end

    assign w_frame_ok = ~r_shreg[10] & r_shreg[0] & (^r_shreg[9:1]);

    always_comb begin
        w_state_nxt     = r_state;
        w_shreg_nxt     = r_shreg;
        w_bitcnt_nxt    = r_bitcnt;
        w_gap_nxt       = r_gap;
        w_frame_out_nxt = r_frame_out;
        w_key_nxt       = r_key;
        w_break_nxt     = r_break;
        w_valid_nxt     = 1'b0;
        w_err_nxt       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_gap_nxt = '0;
                if (w_fall && !r_dat_s2) begin
                    w_shreg_nxt  = w_shifted;
                    w_bitcnt_nxt = 4'd1;
                    w_state_nxt  = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (w_fall) begin
                    w_shreg_nxt  = w_shifted;
                    w_bitcnt_nxt = r_bitcnt + 4'd1;
                    w_gap_nxt    = '0;
                    if (r_bitcnt == 4'd10) begin
                        w_state_nxt = ST_CHECK;
                    end
                end else if (r_gap >= GAP_MAX) begin
                    w_err_nxt    = 1'b1;
                    w_bitcnt_nxt = '0;
                    w_gap_nxt    = '0;
                    w_state_nxt  = ST_IDLE;
                end else begin
                    w_gap_nxt = r_gap + 1'b1;
                end
            end

            ST_CHECK: begin
                w_bitcnt_nxt = '0;
                w_state_nxt  = ST_IDLE;
                if (w_frame_ok) begin
                    w_frame_out_nxt = r_shreg;
                    w_valid_nxt     = 1'b1;
                    if (w_byte == 8'hF0) begin
                        w_break_nxt = 1'b1;
                    end else if (w_byte == 8'hE0) begin
                        w_break_nxt = r_break;
                    end else if (r_break) begin
                        w_break_nxt = 1'b0;
                        if (r_shreg == r_key) begin
                            w_key_nxt = '0;
                        end
                    end else begin
                        w_key_nxt = r_shreg;
                    end
                end else begin
                    w_err_nxt = 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign keyFrame   = r_key;
    assign frameOut   = r_frame_out;
    assign frameValid = r_valid;
    assign frameErr   = r_err;

endmodule

// File: doc/ps2_frame_receiver.md
Name: ps2_frame_receiver

Overview:
- Upstream stage of the PS/2 button decoder.
- Samples the raw PS/2 keyboard clock/data lines in the system clock domain and assembles 11-bit frames: start, 8 data bits LSB-first, odd parity, stop.
- Validates each frame and tracks make/break (0xF0) codes.
- Presents a held 11-bit frame of the currently pressed key on keyFrame; the combinational decoder maps keyFrame to LEDs.

Parameters:
FILTER_LEN, 4, consecutive identical synchronized ps2Clk samples required before the filtered clock changes level
TIMEOUT_CYCLES, 100000, system clocks allowed between ps2Clk falling edges inside a frame before abort (2 ms at 50 MHz)

Ports:
clk  input  1  system clock, all state on rising edge
resetN  input  1  asynchronous active-low reset
ps2Clk  input  1  raw PS/2 clock, asynchronous to clk
ps2Data  input  1  raw PS/2 data, asynchronous to clk
keyFrame  output  11  frame of key currently held; 0 when no key held
frameOut  output  11  last valid frame received (make or break)
frameValid  output  1  one-cycle pulse when frameOut updates
frameErr  output  1  one-cycle pulse on start/stop/parity error or timeout

Behaviour:
- Reset (resetN low, async): all outputs 0, FSM IDLE, counters 0, breakPending 0, filtered clock 1, synchronizers 1.
- Input conditioning:
  - Two-flop synchronizer on ps2Clk and ps2Data.
  - Glitch filter: the filtered clock changes only after FILTER_LEN consecutive equal synchronized samples.
  - A falling edge of the filtered clock produces a one-cycle fall strobe.
  - Data is sampled from synchronized ps2Data in the fall-strobe cycle.
- Frame bit order: shift left, shreg <= {shreg[9:0], bit}. After 11 bits: shreg[10]=start, shreg[9:2]=d0..d7, shreg[1]=parity, shreg[0]=stop. Scan code 0x1C yields 11'd225.
- FSM:
  - IDLE: on fall strobe with data 0, shift bit in, bitCnt<=1, go SHIFT. Fall strobe with data 1 is ignored and the FSM stays IDLE.
  - SHIFT: each fall strobe shifts one bit and increments bitCnt. When bitCnt reaches 11, go CHECK. A gap counter resets on each strobe; if it reaches TIMEOUT_CYCLES, pulse frameErr, go IDLE, discard bits.
  - CHECK (1 cycle): valid = start==0, stop==1, XOR of d0..d7 and parity == 1.
    - Valid: frameOut<=shreg, frameValid pulses the same cycle frameOut changes, then apply the key-tracking rules.
    - Invalid: frameErr pulses; frameOut, keyFrame and breakPending are unchanged.
    - Next state IDLE in both cases.
- Latency: frameValid is asserted 2 clk cycles after the cycle whose fall strobe captures the stop bit.
- Key tracking on a valid frame, data byte D = {d7..d0}:
  - D==0xF0: breakPending<=1; keyFrame unchanged.
  - D==0xE0: ignored for keyFrame; breakPending unchanged.
  - Otherwise with breakPending==1: clear breakPending; if the frame equals keyFrame, keyFrame<=0; otherwise keyFrame is unchanged (release of a non-held key).
  - Otherwise (make code): keyFrame<=frame. Typematic repeats of the same make rewrite the identical value.
- Boundaries:
  - Fall strobe in CHECK is ignored; a frame needs an idle-high clock before its start bit.
  - Timeout in SHIFT with bitCnt 10 still aborts.
  - The timeout counter saturates and does not wrap; it is active only in SHIFT.
  - resetN asserted mid-frame clears everything immediately; no pulse is emitted on reset release.
  - A ps2Clk glitch shorter than FILTER_LEN clk cycles produces no strobe.
  - frameValid and frameErr are never asserted in the same cycle.

Test Plan:
- Send make 0x1C (bits 0,0,0,1,1,1,0,0,0,0,1 with parity 0) -> frameOut=225, frameValid single pulse, keyFrame=225, frameErr=0.
- Send 0x1C, then 0xF0, then 0x1C -> keyFrame 225 after the first frame, still 225 after 0xF0, 0 after the final 0x1C; three frameValid pulses.
- Send 0x1C with the parity bit flipped -> frameErr pulse, no frameValid, frameOut and keyFrame stay 0.
- Send 6 bits, then hold ps2Clk high for TIMEOUT_CYCLES+5 clocks -> frameErr pulse; a following valid 0x24 frame is received correctly.
- Inject 2-cycle low pulses on ps2Clk mid-frame (FILTER_LEN=4) -> no extra bits; the frame decodes correctly.
- Assert resetN for 1 cycle after 5 bits of a frame -> all outputs 0 immediately; the next full 0x1C frame decodes to 225.
